// File: rtl/udma_i2c_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// udma_i2c_cmd_arbiter
//
// Shares the byte-wide command input of the I2C control engine between
// N_REQ independent command sources. Ownership is transaction-atomic: once a
// source has forwarded START it keeps the grant until its STOP, so bus
// transactions never interleave. The command stream is parsed to find the
// transaction boundaries. The next owner is chosen round-robin, starting the
// search just after the previous owner.
//
// Parameters:
//   N_REQ           number of requesters (2..8)
//   TIMEOUT_CYCLES  owner-stall limit in clk_i cycles (1..65535), used only
//                   when I2C_ARB_TIMEOUT_EN is defined
//
// Build option:
//   I2C_ARB_TIMEOUT_EN  adds a 16-bit stall counter. When the owner stalls
//                       for TIMEOUT_CYCLES cycles, the grant is revoked. If a
//                       transaction is open, a STOP (0x20) is injected first.
//                       Without it, err_o is tied to 0 and a stalled owner
//                       keeps the grant indefinitely.
//
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   req_data_i     per-requester command byte, requester k in [8k+7:8k]
//   req_valid_i    per-requester byte valid
//   req_ready_o    per-requester byte accepted (only the owner sees ready)
//   cmd_data_o     byte to the I2C control engine
//   cmd_valid_o    byte valid towards the engine
//   cmd_ready_i    engine accepts the byte
//   grant_o        one-hot current owner, 0 when idle
//   busy_o         a grant is held
//   in_txn_o       START forwarded and STOP not yet forwarded
//   done_o         1-cycle pulse on the owner's bit after grant release
//   err_o          1-cycle pulse after a timeout abort
// ---------------------------------------------------------------------------
module udma_i2c_cmd_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [8*N_REQ-1:0] req_data_i,
   input  logic [N_REQ-1:0]   req_valid_i,
   output logic [N_REQ-1:0]   req_ready_o,
   output logic [7:0]         cmd_data_o,
   output logic               cmd_valid_o,
   input  logic               cmd_ready_i,
   output logic [N_REQ-1:0]   grant_o,
   output logic               busy_o,
   output logic               in_txn_o,
   output logic [N_REQ-1:0]   done_o,
   output logic               err_o
);

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [2:0] OP_START   = 3'd0;
   localparam logic [2:0] OP_STOP    = 3'd1;
   localparam logic [2:0] OP_RD_ACK  = 3'd2;
   localparam logic [2:0] OP_RD_NACK = 3'd3;
   localparam logic [2:0] OP_WR      = 3'd4;
   localparam logic [2:0] OP_WAIT    = 3'd5;
   localparam logic [2:0] OP_RPT     = 3'd6;
   localparam logic [2:0] OP_CFG     = 3'd7;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
      $error("udma_i2c_cmd_arbiter: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_OPND,
      S_RPT_CNT,
      S_RPT_CMD
   } state_t;

   state_t           state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    last_q, last_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] done_q, done_d;
   logic             in_txn_q, in_txn_d;
   logic [7:0]       opnd_q, opnd_d;
   logic [7:0]       cnt_q, cnt_d;

   logic             granted;
   logic             owner_valid;
   logic [7:0]       owner_data;
   logic             hs;
   logic             tmo;
   logic             rel;
   logic             eoc;
   logic [OW-1:0]    pick;

   // Round-robin search: the lowest offset above 'last' with valid set wins.
   // The loop runs downward so that the nearest candidate is assigned last.
   function automatic logic [OW-1:0] pick_next(input logic [OW-1:0]    last,
                                               input logic [N_REQ-1:0] v);
      logic [OW-1:0] sel;
      int            idx;
      sel = last;
      for (int i = N_REQ; i >= 1; i--) begin
         idx = (int'(last) + i) % N_REQ;
         if (v[idx]) sel = OW'(idx);
      end
      return sel;
   endfunction

`ifdef I2C_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);
   logic [15:0] stall_q, stall_d;
   logic        err_q, err_d;

   // The stall limit has been reached. From now on the owner is cut off.
   assign tmo   = granted && (stall_q == TO_LIM);
   assign err_o = err_q;
`else
   assign tmo   = 1'b0;
   assign err_o = 1'b0;
`endif

   assign granted  = |grant_q;
   assign grant_o  = grant_q;
   assign busy_o   = granted;
   assign in_txn_o = in_txn_q;
   assign done_o   = done_q;
   assign pick     = pick_next(last_q, req_valid_i);

   // Combinational passthrough from the owner. During an in-transaction abort,
   // the arbiter drives its own STOP byte and holds the owner's ready low.
   always_comb begin
      owner_valid = req_valid_i[owner_q];
      owner_data  = req_data_i[int'(owner_q)*8 +: 8];
      req_ready_o = '0;
      cmd_data_o  = '0;
      cmd_valid_o = 1'b0;
      if (tmo) begin
         if (in_txn_q) begin
            cmd_data_o  = 8'h20;
            cmd_valid_o = 1'b1;
         end
      end else if (granted) begin
         cmd_data_o           = owner_data;
         cmd_valid_o          = owner_valid;
         req_ready_o[owner_q] = cmd_ready_i;
      end
   end

   assign hs = granted && !tmo && owner_valid && cmd_ready_i;

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      grant_d  = grant_q;
      in_txn_d = in_txn_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      done_d   = '0;
      rel      = 1'b0;
      eoc      = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      err_d    = 1'b0;
      stall_d  = stall_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (|req_valid_i) begin
               owner_d       = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               state_d       = S_CMD;
            end
         end
         S_CMD: begin
            if (hs) begin
               case (owner_data[7:5])
                  OP_START:              in_txn_d = 1'b1;
                  OP_STOP:               rel      = 1'b1;
                  OP_RD_ACK, OP_RD_NACK: eoc      = 1'b1;
                  OP_WR, OP_WAIT: begin
                     opnd_d  = 8'd1;
                     state_d = S_OPND;
                  end
                  OP_CFG: begin
                     opnd_d  = 8'd2;
                     state_d = S_OPND;
                  end
                  OP_RPT:                state_d  = S_RPT_CNT;
                  default:               state_d  = S_CMD;
               endcase
            end
         end
         S_OPND: begin
            if (hs) begin
               if (opnd_q == 8'd1) eoc    = 1'b1;
               else                opnd_d = opnd_q - 8'd1;
            end
         end
         S_RPT_CNT: begin
            if (hs) begin
               cnt_d   = owner_data;
               state_d = S_RPT_CMD;
            end
         end
         S_RPT_CMD: begin
            // Only a repeated WR carries operands. A repeated STOP, START, RPT
            // or CFG byte is treated as a plain one-byte command.
            if (hs) begin
               if (owner_data[7:5] == OP_WR && cnt_q != 8'd0) begin
                  opnd_d  = cnt_q;
                  state_d = S_OPND;
               end else begin
                  eoc = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // End of command: a grant without an open transaction covers one command.
      if (eoc) begin
         if (in_txn_q) state_d = S_CMD;
         else          rel     = 1'b1;
      end

`ifdef I2C_ARB_TIMEOUT_EN
      // Without an open transaction the grant is dropped at once. Otherwise it
      // is dropped when the engine accepts the injected STOP.
      if (tmo && (!in_txn_q || cmd_ready_i)) begin
         rel   = 1'b1;
         err_d = 1'b1;
      end
`endif

      if (rel) begin
         grant_d  = '0;
         in_txn_d = 1'b0;
         last_d   = owner_q;
         done_d   = grant_q;
         state_d  = S_IDLE;
      end

`ifdef I2C_ARB_TIMEOUT_EN
      if (!granted || hs || rel) stall_d = '0;
      else if (stall_q != TO_LIM) stall_d = stall_q + 16'd1;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         last_q   <= OW'(N_REQ - 1);
         grant_q  <= '0;
         in_txn_q <= 1'b0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         in_txn_q <= in_txn_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end
`endif

endmodule
